// File: rtl/bcd_key_entry.sv
// bcd_key_entry
//   Consumes the 4-bit code from a 10-line-to-4-line BCD priority encoder
//   (0000-1001 = key 0-9, anything else = no key). It debounces both press
//   and release, emits one strobe for each accepted press, and shifts each
//   accepted digit into a packed multi-digit BCD entry register.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   code_i[3:0]  encoder code; values above 1001 mean "no key"
//   clear_i      synchronous clear of the entry register, count and overflow
//   digits_o     packed BCD digits; [3:0] holds the most recent digit
//   count_o      number of valid digits; saturates at DIGITS
//   key_valid_o  one-cycle strobe for each accepted press
//   key_code_o   code of the last accepted key; held until the next accept
//   overflow_o   sticky; set when a key is accepted while count_o == DIGITS
//
// Build option
//   BCD_ENTRY_LOCK_EN: when defined, an accept into a full entry register
//   leaves digits_o frozen instead of dropping the oldest digit.

module bcd_key_entry #(
  parameter int DIGITS     = 4,
  parameter int DEB_CYCLES = 12000,
  localparam int CW = $clog2(DIGITS + 1),
  localparam int DW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES - 1) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            code_i,
  input  logic                  clear_i,
  output logic [4*DIGITS-1:0]   digits_o,
  output logic [CW-1:0]         count_o,
  output logic                  key_valid_o,
  output logic [3:0]            key_code_o,
  output logic                  overflow_o
);

  typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_REL} state_t;

  state_t                r_state;
  logic [3:0]            r_cand;
  logic [DW-1:0]         r_cnt;
  logic [4*DIGITS-1:0]   r_digits;
  logic [CW-1:0]         r_count;
  logic                  r_key_valid;
  logic [3:0]            r_key_code;
  logic                  r_overflow;

  logic                  w_key;
  logic                  w_last;
  logic                  w_accept;
  logic                  w_full;
  logic [4*DIGITS-1:0]   w_shift;

  assign w_key  = (code_i <= 4'd9);
  // The edge that enters a debounce state with cnt = 0 already counts as the
  // first stable sample, so DEB_CYCLES samples end when cnt == DEB_CYCLES-2.
  assign w_last = (r_cnt == DW'(DEB_CYCLES - 2));
  assign w_accept = (r_state == DEB_PRESS) && (code_i == r_cand) && w_last;
  assign w_full = (r_count == CW'(DIGITS));

  generate
    if (DIGITS == 1) begin : g_one
      assign w_shift = r_cand;
    end else begin : g_multi
      assign w_shift = {r_digits[4*DIGITS-5:0], r_cand};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cand      <= '0;
      r_cnt       <= '0;
      r_digits    <= '0;
      r_count     <= '0;
      r_key_valid <= 1'b0;
      r_key_code  <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_key_valid <= w_accept;

      case (r_state)
        IDLE: begin
          if (w_key) begin
            r_state <= DEB_PRESS;
            r_cand  <= code_i;
            r_cnt   <= '0;
          end
        end
        DEB_PRESS: begin
          if (!w_key) begin
            r_state <= IDLE;
          end else if (code_i != r_cand) begin
            r_cand <= code_i;
            r_cnt  <= '0;
          end else if (w_last) begin
            r_state <= HELD;
          end else begin
            r_cnt <= r_cnt + DW'(1);
          end
        end
        HELD: begin
          if (!w_key) begin
            r_state <= DEB_REL;
            r_cnt   <= '0;
          end
        end
        DEB_REL: begin
          if (w_key) begin
            r_state <= HELD;
          end else if (w_last) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + DW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_accept) begin
        r_key_code <= r_cand;
      end

      // Clear takes priority over storing a coincident digit.
      if (clear_i) begin
        r_digits   <= '0;
        r_count    <= '0;
        r_overflow <= 1'b0;
      end else if (w_accept) begin
        if (w_full) begin
          r_overflow <= 1'b1;
`ifndef BCD_ENTRY_LOCK_EN
          r_digits   <= w_shift;
`endif
        end else begin
          r_digits <= w_shift;
          r_count  <= r_count + CW'(1);
        end
      end
    end
  end

  assign digits_o    = r_digits;
  assign count_o     = r_count;
  assign key_valid_o = r_key_valid;
  assign key_code_o  = r_key_code;
  assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_bcd_key_entry.sv
// tb_bcd_key_entry
//   Directed bench for bcd_key_entry with DIGITS=4, DEB_CYCLES=4.
//   Inputs change 1 ns after a rising edge; outputs are read at that point.

module tb_bcd_key_entry;

  logic        clk;
  logic        rst_n;
  logic [3:0]  code_i;
  logic        clear_i;
  logic [15:0] digits_o;
  logic [2:0]  count_o;
  logic        key_valid_o;
  logic [3:0]  key_code_o;
  logic        overflow_o;

  int unsigned n_checks;
  int unsigned n_errors;
  int unsigned pulses;
  int unsigned p0;

  bcd_key_entry #(.DIGITS(4), .DEB_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .code_i      (code_i),
    .clear_i     (clear_i),
    .digits_o    (digits_o),
    .count_o     (count_o),
    .key_valid_o (key_valid_o),
    .key_code_o  (key_code_o),
    .overflow_o  (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each strobe is high for one full cycle, so it is seen on exactly one
  // falling edge.
  always @(negedge clk) if (key_valid_o === 1'b1) pulses <= pulses + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Clean press and release, each longer than the debounce window.
  task automatic press(input logic [3:0] c);
    code_i = c;
    tick(6);
    code_i = 4'hF;
    tick(6);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    pulses   = 0;
    rst_n    = 1'b0;
    code_i   = 4'hF;
    clear_i  = 1'b0;
    tick(3);
    rst_n = 1'b1;

    // Idle with no key
    tick(20);
    check("idle_digits", digits_o, 32'h0);
    check("idle_count", count_o, 32'h0);
    check("idle_code", key_code_o, 32'h0);
    check("idle_ovf", overflow_o, 32'h0);
    check("idle_pulses", pulses, 32'd0);

    // Single press of 5: four stable samples, strobe after the fourth edge
    p0 = pulses;
    code_i = 4'h5;
    tick(3);
    check("k5_early", key_valid_o, 32'h0);
    tick(1);
    check("k5_valid", key_valid_o, 32'h1);
    check("k5_code", key_code_o, 32'h5);
    check("k5_digits", digits_o, 32'h0005);
    check("k5_count", count_o, 32'h1);
    tick(1);
    check("k5_strobe_len", key_valid_o, 32'h0);
    tick(5);
    code_i = 4'hF;
    tick(6);
    check("k5_one_pulse", pulses - p0, 32'd1);
    check("k5_code_held", key_code_o, 32'h5);

    // Bounce never reaching four stable samples
    p0 = pulses;
    code_i = 4'h3; tick(2);
    code_i = 4'hF; tick(1);
    code_i = 4'h3; tick(2);
    code_i = 4'hF; tick(6);
    check("bounce_none", pulses - p0, 32'd0);
    check("bounce_digits", digits_o, 32'h0005);
    code_i = 4'h3; tick(6);
    code_i = 4'hF; tick(6);
    check("bounce_one", pulses - p0, 32'd1);
    check("k3_digits", digits_o, 32'h0053);
    check("k3_count", count_o, 32'h2);

    // Invalid codes are "no key"
    p0 = pulses;
    code_i = 4'hA; tick(8);
    code_i = 4'hF; tick(2);
    check("invalid_none", pulses - p0, 32'd0);

    // Clear leaves key_code_o alone
    clear_i = 1'b1; tick(1); clear_i = 1'b0;
    check("clr_digits", digits_o, 32'h0);
    check("clr_count", count_o, 32'h0);
    check("clr_code", key_code_o, 32'h3);

    // Fill, then overflow
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    check("fill_digits", digits_o, 32'h1234);
    check("fill_count", count_o, 32'h4);
    check("fill_ovf", overflow_o, 32'h0);
    press(4'h5);
`ifdef BCD_ENTRY_LOCK_EN
    check("ovf_digits", digits_o, 32'h1234);
`else
    check("ovf_digits", digits_o, 32'h2345);
`endif
    check("ovf_count", count_o, 32'h4);
    check("ovf_flag", overflow_o, 32'h1);
    check("ovf_code", key_code_o, 32'h5);

    // Clear coinciding with accept of 7
    code_i = 4'h7;
    tick(3);
    clear_i = 1'b1;
    tick(1);
    clear_i = 1'b0;
    check("k7_valid", key_valid_o, 32'h1);
    check("k7_code", key_code_o, 32'h7);
    check("k7_digits", digits_o, 32'h0);
    check("k7_count", count_o, 32'h0);
    check("k7_ovf", overflow_o, 32'h0);
    tick(3);
    code_i = 4'hF;
    tick(6);

    // Reset in the middle of press debounce with 8 held
    code_i = 4'h8;
    tick(2);
    rst_n = 1'b0;
    tick(2);
    check("rst_code", key_code_o, 32'h0);
    rst_n = 1'b1;
    tick(3);
    check("k8_early", key_valid_o, 32'h0);
    check("k8_early_digits", digits_o, 32'h0);
    tick(1);
    check("k8_valid", key_valid_o, 32'h1);
    check("k8_digits", digits_o, 32'h0008);
    check("k8_count", count_o, 32'h1);
    check("k8_code", key_code_o, 32'h8);
    code_i = 4'hF;
    tick(6);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
